// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, LSB-first word into a
// single-entry holding register with a valid/ready stream plus frame-error and overrun pulses.
module uart_rx #(
    parameter int clk_rate = 100000000,
    parameter int Baud     = 115200,
    parameter int Word_len = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Uart_rx,
    output logic [Word_len-1:0] rx_data,
    output logic                rx_data_valid,
    input  logic                rx_data_ready,
    output logic                rx_frame_err,
    output logic                rx_overrun
);

    localparam int Baud_div = clk_rate / Baud;
    localparam int BW       = $clog2(Baud_div) + 1;
    localparam int CW       = $clog2(Word_len + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(Baud_div - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(Baud_div / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(Word_len - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic                r_sync1, r_sync2, r_rxs_prev;
    state_t              r_state, w_state_nx;
    logic [BW-1:0]       r_baud_cnt, w_baud_cnt_nx;
    logic [CW-1:0]       r_bit_cnt, w_bit_cnt_nx;
    logic [Word_len-1:0] r_shift, w_shift_nx;
    logic [Word_len-1:0] r_data, w_data_nx;
    logic                r_valid, w_valid_nx;
    logic                r_ferr, w_ferr_nx;
    logic                r_ovr, w_ovr_nx;
    logic                w_rxs;

    assign w_rxs = r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxs_prev <= 1'b1;
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_sync1    <= Uart_rx;
            r_sync2    <= r_sync1;
            r_rxs_prev <= w_rxs;
            r_state    <= w_state_nx;
            r_baud_cnt <= w_baud_cnt_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_shift    <= w_shift_nx;
            r_data     <= w_data_nx;
            r_valid    <= w_valid_nx;
            r_ferr     <= w_ferr_nx;
            r_ovr      <= w_ovr_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_baud_cnt_nx = r_baud_cnt;
        w_bit_cnt_nx  = r_bit_cnt;
        w_shift_nx    = r_shift;
        w_data_nx     = r_data;
        w_valid_nx    = r_valid && !rx_data_ready;
        w_ferr_nx     = 1'b0;
        w_ovr_nx      = 1'b0;

        case (r_state)
            IDLE: begin
                // Edge-triggered start: a line that stays low never retriggers.
                if (!w_rxs && r_rxs_prev) begin
                    w_state_nx    = START;
                    w_baud_cnt_nx = '0;
                    w_bit_cnt_nx  = '0;
                end
            end
            START: begin
                if (r_baud_cnt == HALF_LAST) begin
                    w_baud_cnt_nx = '0;
                    w_state_nx    = w_rxs ? IDLE : DATA;
                end else begin
                    w_baud_cnt_nx = r_baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_baud_cnt == BAUD_LAST) begin
                    w_baud_cnt_nx = '0;
                    w_shift_nx    = {w_rxs, r_shift[Word_len-1:1]};
                    w_bit_cnt_nx  = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_nx = STOP;
                    end
                end else begin
                    w_baud_cnt_nx = r_baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_baud_cnt == BAUD_LAST) begin
                    w_baud_cnt_nx = '0;
                    w_state_nx    = IDLE;
                    if (!w_rxs) begin
                        w_ferr_nx = 1'b1;
                    end else if (!r_valid || rx_data_ready) begin
                        w_data_nx  = r_shift;
                        w_valid_nx = 1'b1;
                    end else begin
                        w_ovr_nx = 1'b1;
                    end
                end else begin
                    w_baud_cnt_nx = r_baud_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx    = IDLE;
                w_baud_cnt_nx = '0;
                w_bit_cnt_nx  = '0;
            end
        endcase
    end

    assign rx_data       = r_data;
    assign rx_data_valid = r_valid;
    assign rx_frame_err  = r_ferr;
    assign rx_overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected words and flag counts,
// a negedge monitor pops on every handshake and counts flag pulses.
module tb_uart_rx;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready = 1'b1;
    logic       rx_frame_err;
    logic       rx_overrun;

    int         checks = 0;
    int         errors = 0;
    int         n_ferr = 0, exp_ferr = 0;
    int         n_ovr  = 0, exp_ovr  = 0;
    logic       model_hold = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx #(.clk_rate(1000000), .Baud(100000), .Word_len(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .Uart_rx       (Uart_rx),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what one frame must produce given the stop bit and the holding state.
    function automatic void expect_frame(input logic [7:0] d, input logic stop_ok);
        if (!stop_ok)
            exp_ferr++;
        else if (model_hold)
            exp_ovr++;
        else begin
            exp_q.push_back(d);
            model_hold = !rx_data_ready;
        end
    endfunction

    task automatic send_bit(input logic b);
        Uart_rx = b;
        repeat (DIV) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        expect_frame(d, stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop_bit);
    endtask

    task automatic idle_bits(input int n);
        Uart_rx = 1'b1;
        repeat (n * DIV) tick();
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_ferr_count"}, n_ferr, exp_ferr);
        chk({tag, "_ovr_count"}, n_ovr, exp_ovr);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_data_valid && rx_data_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {24'h0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("rx_data", {24'h0, rx_data}, {24'h0, e});
                end
            end
            if (rx_frame_err) n_ferr++;
            if (rx_overrun)   n_ovr++;
        end
    end

    initial begin
        logic [7:0] d;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_data", {24'h0, rx_data}, 0);
        chk("reset_valid", rx_data_valid, 0);
        chk("reset_ferr", rx_frame_err, 0);
        chk("reset_ovr", rx_overrun, 0);
        idle_bits(2);

        // Single good frame, ready high
        send_frame(8'hA5, 1'b1);
        idle_bits(2);
        chk_flags("a5");

        // Overrun: hold 0x3C, drop 0x55
        rx_data_ready = 1'b0;
        send_frame(8'h3C, 1'b1);
        idle_bits(1);
        send_frame(8'h55, 1'b1);
        idle_bits(1);
        chk("ovr_valid_held", rx_data_valid, 1);
        chk("ovr_data_held", {24'h0, rx_data}, 32'h3C);
        chk("ovr_count", n_ovr, exp_ovr);
        rx_data_ready = 1'b1;
        model_hold = 1'b0;
        repeat (3) tick();
        chk("ovr_valid_cleared", rx_data_valid, 0);
        chk_flags("ovr");

        // Frame error, then line stuck low, then recovery
        send_frame(8'hFF, 1'b0);
        repeat (3) tick();
        chk("ferr_no_valid", rx_data_valid, 0);
        Uart_rx = 1'b0;
        repeat (30 * DIV) tick();
        chk_flags("stuck_low");
        idle_bits(2);
        send_frame(8'h12, 1'b1);
        idle_bits(2);
        chk_flags("recover");

        // Short low glitch on an idle line
        Uart_rx = 1'b0;
        repeat (3) tick();
        idle_bits(3);
        chk_flags("glitch");

        // Reset during bit 4 of 0x81, released during bit 7 (line high)
        d = 8'h81;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        Uart_rx = d[4];
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_valid", rx_data_valid, 0);
        repeat (4) tick();
        send_bit(d[5]);
        send_bit(d[6]);
        Uart_rx = d[7];
        repeat (3) tick();
        rst = 1'b0;
        repeat (7) tick();
        send_bit(1'b1);
        idle_bits(2);
        send_frame(8'h7E, 1'b1);
        idle_bits(2);
        chk_flags("rst_mid");

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h5A, 1'b1);
        idle_bits(2);
        chk_flags("b2b");

        // Randomised frames, occasional bad stop bits and random gaps
        for (int n = 0; n < 24; n++) begin
            logic good;
            int   gap;
            d    = 8'($urandom);
            good = ($urandom_range(0, 9) != 0);
            gap  = $urandom_range(0, 3);
            if (!good && gap == 0) gap = 1;
            send_frame(d, good);
            if (gap > 0) idle_bits(gap);
        end
        idle_bits(2);

        for (int w = 0; w < 50 && exp_q.size() != 0; w++) tick();
        chk_flags("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
